// File: rtl/alt_vipcti131_common_avalon_st_decoder.sv
// Avalon-ST video packet decoder: strips packet headers, decodes control packets
// into frame width/height/interlace, and forwards payload beats through one output register.
module alt_vipcti131_common_avalon_st_decoder #(
  parameter int unsigned BITS_PER_SYMBOL  = 8,
  parameter int unsigned SYMBOLS_PER_BEAT = 3,
  parameter int unsigned DEFAULT_WIDTH    = 640,
  parameter int unsigned DEFAULT_HEIGHT   = 480
) (
  input  logic                                        clk,
  input  logic                                        rst,
  output logic                                        din_ready,
  input  logic                                        din_valid,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
  input  logic                                        din_startofpacket,
  input  logic                                        din_endofpacket,
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic [15:0]                                 decoder_width,
  output logic [15:0]                                 decoder_height,
  output logic [3:0]                                  decoder_interlaced,
  output logic                                        decoder_end_of_video,
  output logic                                        decoder_is_video,
  output logic                                        decoder_vip_ctrl_valid
);

  localparam int unsigned DW        = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int unsigned N_NIBBLES = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VIDEO,
    ST_CTRL,
    ST_OTHER
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [35:0]     shadow_q, shadow_d;
  logic            dout_valid_q, dout_valid_d;
  logic [DW-1:0]   dout_data_q, dout_data_d;
  logic            is_video_q, is_video_d;
  logic            eov_q, eov_d;
  logic [15:0]     width_q, width_d;
  logic [15:0]     height_q, height_d;
  logic [3:0]      interlaced_q, interlaced_d;
  logic            vip_q, vip_d;
  logic [31:0]     nib_sum;
  logic            accept;

  assign din_ready = ~dout_valid_q | dout_ready;
  assign accept    = din_valid & din_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    dout_valid_d = dout_valid_q & ~dout_ready;
    dout_data_d  = dout_data_q;
    is_video_d   = is_video_q;
    eov_d        = eov_q;
    width_d      = width_q;
    height_d     = height_q;
    interlaced_d = interlaced_q;
    vip_d        = 1'b0;
    nib_sum      = '0;

    if (accept) begin
      if (din_startofpacket) begin
        cnt_d = '0;
        if (din_endofpacket) begin
          state_d = ST_IDLE;
        end else begin
          case (din_data[3:0])
            4'h0:    state_d = ST_VIDEO;
            4'hF:    state_d = ST_CTRL;
            default: state_d = ST_OTHER;
          endcase
        end
      end else begin
        case (state_q)
          ST_VIDEO, ST_OTHER: begin
            dout_valid_d = 1'b1;
            dout_data_d  = din_data;
            is_video_d   = (state_q == ST_VIDEO);
            eov_d        = (state_q == ST_VIDEO) & din_endofpacket;
            if (din_endofpacket) state_d = ST_IDLE;
          end
          ST_CTRL: begin
            // Symbol s of this beat carries nibble cnt_q+s; nibbles past the interlace field are dropped.
            for (int unsigned s = 0; s < SYMBOLS_PER_BEAT; s++) begin
              if (32'(cnt_q) + s < N_NIBBLES)
                shadow_d[35 - 4*(32'(cnt_q) + s) -: 4] = din_data[s*BITS_PER_SYMBOL +: 4];
            end
            nib_sum = 32'(cnt_q) + SYMBOLS_PER_BEAT;
            cnt_d   = (nib_sum >= N_NIBBLES) ? 4'(N_NIBBLES) : nib_sum[3:0];
            if (din_endofpacket) begin
              state_d = ST_IDLE;
              if (nib_sum >= N_NIBBLES) begin
                width_d      = shadow_d[35:20];
                height_d     = shadow_d[19:4];
                interlaced_d = shadow_d[3:0];
                vip_d        = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shadow_q     <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      is_video_q   <= 1'b0;
      eov_q        <= 1'b0;
      width_q      <= 16'(DEFAULT_WIDTH);
      height_q     <= 16'(DEFAULT_HEIGHT);
      interlaced_q <= '0;
      vip_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      is_video_q   <= is_video_d;
      eov_q        <= eov_d;
      width_q      <= width_d;
      height_q     <= height_d;
      interlaced_q <= interlaced_d;
      vip_q        <= vip_d;
    end
  end

  assign dout_valid             = dout_valid_q;
  assign dout_data              = dout_data_q;
  assign decoder_width          = width_q;
  assign decoder_height         = height_q;
  assign decoder_interlaced     = interlaced_q;
  assign decoder_end_of_video   = eov_q;
  assign decoder_is_video       = is_video_q;
  assign decoder_vip_ctrl_valid = vip_q;

endmodule

// File: tb/tb_alt_vipcti131_common_avalon_st_decoder.sv
// Scoreboard bench for the Avalon-ST decoder: forwarded beats are predicted on
// acceptance and compared when the output handshake completes.
module tb_alt_vipcti131_common_avalon_st_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_ready;
  logic        din_valid;
  logic [23:0] din_data;
  logic        din_startofpacket;
  logic        din_endofpacket;
  logic        dout_ready;
  logic        dout_valid;
  logic [23:0] dout_data;
  logic [15:0] decoder_width;
  logic [15:0] decoder_height;
  logic [3:0]  decoder_interlaced;
  logic        decoder_end_of_video;
  logic        decoder_is_video;
  logic        decoder_vip_ctrl_valid;

  alt_vipcti131_common_avalon_st_decoder #(
    .BITS_PER_SYMBOL (8),
    .SYMBOLS_PER_BEAT(3),
    .DEFAULT_WIDTH   (640),
    .DEFAULT_HEIGHT  (480)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .din_ready             (din_ready),
    .din_valid             (din_valid),
    .din_data              (din_data),
    .din_startofpacket     (din_startofpacket),
    .din_endofpacket       (din_endofpacket),
    .dout_ready            (dout_ready),
    .dout_valid            (dout_valid),
    .dout_data             (dout_data),
    .decoder_width         (decoder_width),
    .decoder_height        (decoder_height),
    .decoder_interlaced    (decoder_interlaced),
    .decoder_end_of_video  (decoder_end_of_video),
    .decoder_is_video      (decoder_is_video),
    .decoder_vip_ctrl_valid(decoder_vip_ctrl_valid)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pop_cnt  = 0;
  int unsigned pulse_cnt = 0;
  logic [15:0] pulse_width, pulse_height;
  logic [25:0] sb_q[$];   // {is_video, end_of_video, data}
  int          m_state = 0; // 0 idle, 1 video, 2 other, 3 control

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && dout_valid && dout_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("dout_unexpected", sb_q.size(), 1);
      end else begin
        check_eq("dout_beat", {decoder_is_video, decoder_end_of_video, dout_data}, sb_q.pop_front());
        pop_cnt++;
      end
    end
    if (rst && decoder_vip_ctrl_valid) begin
      pulse_cnt++;
      pulse_width  = decoder_width;
      pulse_height = decoder_height;
    end
  end

  task automatic send(input logic [23:0] d, input logic sop, input logic eop);
    logic got_ready;
    logic [3:0] ptype;
    got_ready         = 1'b0;
    din_valid         = 1'b1;
    din_data          = d;
    din_startofpacket = sop;
    din_endofpacket   = eop;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (din_ready) begin
        got_ready = 1'b1;
        break;
      end
    end
    if (!got_ready) begin
      check_eq("din_ready_timeout", din_ready, 1);
    end else begin
      ptype = d[3:0];
      if (sop) begin
        if (eop)               m_state = 0;
        else if (ptype == 4'h0) m_state = 1;
        else if (ptype == 4'hF) m_state = 3;
        else                    m_state = 2;
      end else if (m_state == 1 || m_state == 2) begin
        sb_q.push_back({m_state == 1, (m_state == 1) && eop, d});
        if (eop) m_state = 0;
      end else if (m_state == 3 && eop) begin
        m_state = 0;
      end
    end
    @(posedge clk);
    #1;
    din_valid         = 1'b0;
    din_startofpacket = 1'b0;
    din_endofpacket   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb_q.size() == 0 && !dout_valid) break;
      @(negedge clk);
    end
    check_eq("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p0, c0;
    rst = 1'b0; din_valid = 1'b0; din_data = '0;
    din_startofpacket = 1'b0; din_endofpacket = 1'b0; dout_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_eq("rst_dout_valid", dout_valid, 0);
    check_eq("rst_dout_data", dout_data, 0);
    check_eq("rst_width", decoder_width, 640);
    check_eq("rst_height", decoder_height, 480);
    check_eq("rst_interlaced", decoder_interlaced, 0);
    check_eq("rst_flags", {decoder_end_of_video, decoder_is_video, decoder_vip_ctrl_valid}, 0);
    @(posedge clk); #1; rst = 1'b1;

    // control packet: 1920x1080 progressive
    c0 = pulse_cnt;
    send(24'h00000F, 1, 0);
    send(24'h080700, 0, 0);
    send(24'h040000, 0, 0);
    send(24'h000803, 0, 1);
    repeat (3) @(negedge clk);
    check_eq("ctrl_pulse_count", pulse_cnt - c0, 1);
    check_eq("ctrl_width_at_pulse", pulse_width, 16'h0780);
    check_eq("ctrl_height_at_pulse", pulse_height, 16'h0438);
    check_eq("ctrl_width", decoder_width, 16'h0780);
    check_eq("ctrl_height", decoder_height, 16'h0438);
    check_eq("ctrl_interlaced", decoder_interlaced, 0);

    // video packet with a two-cycle downstream stall on beat 2
    send(24'h000000, 1, 0);
    send(24'h111111, 0, 0);
    send(24'h222222, 0, 0);
    dout_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("stall_din_ready", din_ready, 0);
      check_eq("stall_dout_hold", {dout_valid, dout_data}, {1'b1, 24'h222222});
    end
    @(posedge clk); #1; dout_ready = 1'b1;
    send(24'h333333, 0, 1);
    drain();

    // short control packet leaves fields untouched
    c0 = pulse_cnt;
    send(24'h00000F, 1, 0);
    send(24'h010203, 0, 0);
    send(24'h040506, 0, 1);
    repeat (3) @(negedge clk);
    check_eq("short_no_pulse", pulse_cnt - c0, 0);
    check_eq("short_width", decoder_width, 16'h0780);
    check_eq("short_height", decoder_height, 16'h0438);

    // ancillary packet forwarded as non-video
    send(24'h000003, 1, 0);
    send(24'hABCDEF, 0, 0);
    send(24'h123456, 0, 1);
    drain();

    // control header interrupts a video packet; extra nibbles beyond 9 ignored
    c0 = pulse_cnt;
    send(24'h000000, 1, 0);
    send(24'h777777, 0, 0);
    send(24'h00000F, 1, 0);
    send(24'hA0F5A0, 0, 0);
    send(24'h020000, 0, 0);
    send(24'h03000D, 0, 0);
    send(24'h0E0E0E, 0, 1);
    repeat (3) @(negedge clk);
    drain();
    check_eq("interrupt_pulse", pulse_cnt - c0, 1);
    check_eq("interrupt_width", decoder_width, 16'h0500);
    check_eq("interrupt_height", decoder_height, 16'h02D0);
    check_eq("interrupt_interlaced", decoder_interlaced, 4'h3);

    // header-only video packet, then a stray beat in IDLE
    p0 = pop_cnt;
    send(24'h000000, 1, 1);
    send(24'h424242, 0, 0);
    repeat (3) @(negedge clk);
    check_eq("hdr_only_no_beat", pop_cnt - p0, 0);
    check_eq("hdr_only_dout_valid", dout_valid, 0);

    // reset in the middle of a video packet
    send(24'h000000, 1, 0);
    send(24'h999999, 0, 0);
    rst = 1'b0;
    #2;
    check_eq("midrst_dout_valid", dout_valid, 0);
    check_eq("midrst_dout_data", dout_data, 0);
    check_eq("midrst_width", decoder_width, 640);
    check_eq("midrst_height", decoder_height, 480);
    check_eq("midrst_flags", {decoder_end_of_video, decoder_is_video, decoder_vip_ctrl_valid, decoder_interlaced}, 0);
    sb_q.delete();
    m_state = 0;
    @(posedge clk); #1; rst = 1'b1;
    p0 = pop_cnt;
    send(24'h555555, 0, 1);
    repeat (3) @(negedge clk);
    check_eq("midrst_idle_discard", pop_cnt - p0, 0);
    check_eq("midrst_idle_dout_valid", dout_valid, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
